// File: rtl/axisrandom_sched_pkg.sv
// Shared types and constants for the AXI-stream PRN burst scheduler.
package axisrandom_sched_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Burst-length code that stands for the maximum burst of 2^LGBURST words
  localparam int BLEN_MAX_CODE = 0;

  // One extra bit so the remaining count can hold 2^LGBURST
  function automatic int cnt_width(input int lgburst);
    return lgburst + 1;
  endfunction

endpackage

// File: rtl/axisrandom_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request at or above i_ptr, wrapping.
module rr_pick #(
  parameter int NR = 4,
  parameter int PW = $clog2(NR)
) (
  input  logic [NR-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_valid,
  output logic [NR-1:0] o_onehot
);

  logic [NR-1:0] mask, hi, sel;

  // Requests at or above the pointer take priority; otherwise wrap to the lowest.
  assign mask     = ~((NR'(1) << i_ptr) - NR'(1));
  assign hi       = i_req & mask;
  assign sel      = (|hi) ? hi : i_req;
  assign o_onehot = sel & (~sel + NR'(1));
  assign o_valid  = |i_req;

endmodule

// File: rtl/axisrandom_scheduler.sv
// Shares one AXI-stream PRN source among NR consumers, one locked burst per grant.
module axisrandom_scheduler
  import axisrandom_sched_pkg::*;
#(
  parameter int NR                = 4,
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int LGBURST           = 4
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESET,
  input  logic [NR-1:0]                i_req,
  input  logic [LGBURST-1:0]           i_burst_len,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic [NR-1:0]                M_AXIS_TVALID,
  input  logic [NR-1:0]                M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                         M_AXIS_TLAST,
  output logic [NR-1:0]                o_grant,
  output logic                         o_busy
);

  localparam int PW = $clog2(NR);
  localparam int CW = cnt_width(LGBURST);
  localparam logic [CW-1:0] BMAX = CW'(2 ** LGBURST);

  state_t          state;
  logic [NR-1:0]   grant;
  logic [PW-1:0]   ptr, gidx;
  logic [CW-1:0]   rem;
  logic            pick_vld, beat, in_burst;
  logic [NR-1:0]   pick_oh;

  rr_pick #(.NR(NR), .PW(PW)) u_pick (
    .i_req   (i_req),
    .i_ptr   (ptr),
    .o_valid (pick_vld),
    .o_onehot(pick_oh)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NR; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign in_burst      = (state == BURST);
  assign S_AXIS_TREADY = in_burst && |(grant & M_AXIS_TREADY);
  assign M_AXIS_TVALID = (in_burst && S_AXIS_TVALID) ? grant : '0;
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TLAST  = in_burst && (rem == CW'(1));
  assign beat          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign o_grant       = grant;
  assign o_busy        = in_burst;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          state <= BURST;
          grant <= pick_oh;
          rem   <= (i_burst_len == LGBURST'(BLEN_MAX_CODE)) ? BMAX : {1'b0, i_burst_len};
        end
        BURST: if (beat) begin
          rem <= rem - CW'(1);
          // Final beat: release the lock and advance past the served port
          if (rem == CW'(1)) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= (gidx == PW'(NR - 1)) ? '0 : gidx + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axisrandom_scheduler.sv
// Directed bench for axisrandom_scheduler: grant latency, round-robin, lengths, stalls, locking, reset.
module tb_axisrandom_scheduler;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int LG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [LG-1:0] blen;
  logic          s_tvalid, s_tready;
  logic [DW-1:0] s_tdata;
  logic [NR-1:0] m_tvalid, m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast, busy;
  logic [NR-1:0] grant;

  int n_cmp = 0;
  int n_err = 0;
  int nbeats;
  logic [DW-1:0] src;

  always #5 clk = ~clk;

  axisrandom_scheduler #(.NR(NR), .C_AXIS_DATA_WIDTH(DW), .LGBURST(LG)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .i_req        (req),
    .i_burst_len  (blen),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TREADY(s_tready),
    .S_AXIS_TDATA (s_tdata),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TREADY(m_tready),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TLAST (m_tlast),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the source advances only on an accepted handshake
  task automatic cyc();
    logic b;
    b = s_tvalid && s_tready;
    @(posedge clk);
    #1;
    if (b) begin
      src++;
      nbeats++;
    end
    s_tdata = src;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic tv, tr;
    src = 32'hA000_0000; s_tdata = src; nbeats = 0;
    rst = 1'b1; req = '0; blen = 4'd3; s_tvalid = 1'b1; m_tready = '1;
    cyc(); cyc();
    settle();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_tlast", m_tlast, 0);

    // Single port, 3-beat burst
    rst = 1'b0; req = 4'b0001; blen = 4'd3;
    settle();
    chk("sp_idle_grant", grant, 0);
    cyc();
    chk("sp_grant", grant, 4'b0001);
    chk("sp_busy", busy, 1);
    chk("sp_tvalid", m_tvalid, 4'b0001);
    chk("sp_tready", s_tready, 1);
    chk("sp_tdata", m_tdata, src);
    chk("sp_tlast1", m_tlast, 0);
    req = '0; nbeats = 0;
    cyc(); settle(); chk("sp_tlast2", m_tlast, 0);
    cyc(); settle(); chk("sp_tlast3", m_tlast, 1);
    cyc(); settle();
    chk("sp_busy_end", busy, 0);
    chk("sp_grant_end", grant, 0);
    chk("sp_beats", nbeats, 3);

    // Round-robin from a fresh pointer: 0,1,2,3,0
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 4'b1111; blen = 4'd2;
    for (int b = 0; b < 5; b++) begin
      nbeats = 0;
      cyc(); settle();
      chk("rr_grant", grant, 4'b0001 << (b % 4));
      chk("rr_tvalid", m_tvalid, 4'b0001 << (b % 4));
      chk("rr_tlast_a", m_tlast, 0);
      cyc(); settle();
      chk("rr_tlast_b", m_tlast, 1);
      cyc(); settle();
      chk("rr_gap_busy", busy, 0);
      chk("rr_beats", nbeats, 2);
    end
    req = '0;

    // Length code 0 -> 16 beats; pointer is now 1
    req = 4'b0010; blen = 4'd0;
    cyc(); settle();
    chk("z_grant", grant, 4'b0010);
    req = '0; blen = 4'd5; nbeats = 0;
    for (int k = 1; k <= 16; k++) begin
      settle();
      chk("z_tlast", m_tlast, (k == 16));
      cyc();
    end
    settle();
    chk("z_beats", nbeats, 16);
    chk("z_busy", busy, 0);

    // Consumer and source stalls on port 2 (pointer now 2)
    req = 4'b0100; blen = 4'd3;
    cyc(); settle();
    chk("st_grant", grant, 4'b0100);
    req = '0; nbeats = 0;
    for (int i = 0; i < 10; i++) begin
      tv = !(i >= 3 && i <= 7);
      tr = !(i == 1 || i == 2);
      s_tvalid = tv;
      m_tready = tr ? 4'b0100 : 4'b1011;
      settle();
      chk("st_tready", s_tready, tr);
      chk("st_tvalid", m_tvalid, tv ? 4'b0100 : 4'b0000);
      chk("st_tlast", m_tlast, (nbeats == 2));
      chk("st_tdata", m_tdata, src);
      cyc();
    end
    s_tvalid = 1'b1; m_tready = '1;
    settle();
    chk("st_beats", nbeats, 3);
    chk("st_busy", busy, 0);

    // Lock: port 1 keeps its burst while port 2 requests (pointer now 3)
    req = 4'b0010; blen = 4'd4;
    cyc(); settle();
    chk("lk_grant", grant, 4'b0010);
    blen = 4'd1; nbeats = 0;
    cyc();
    req = 4'b0100;
    for (int k = 2; k <= 4; k++) begin
      settle();
      chk("lk_tvalid", m_tvalid, 4'b0010);
      chk("lk_tlast", m_tlast, (k == 4));
      cyc();
    end
    settle();
    chk("lk_beats", nbeats, 4);
    chk("lk_gap_busy", busy, 0);
    chk("lk_gap_tvalid", m_tvalid, 0);
    cyc(); settle();
    chk("lk_grant2", grant, 4'b0100);
    chk("lk_tlast2", m_tlast, 1);
    req = '0;
    cyc(); settle();
    chk("lk_busy_end", busy, 0);

    // Reset mid-burst (pointer was 3; reset must return it to 0)
    req = 4'b0001; blen = 4'd5;
    cyc(); settle();
    chk("mr_grant", grant, 4'b0001);
    req = '0;
    cyc(); cyc();
    rst = 1'b1;
    cyc(); settle();
    chk("mr_grant0", grant, 0);
    chk("mr_tvalid", m_tvalid, 0);
    chk("mr_tlast", m_tlast, 0);
    chk("mr_busy", busy, 0);
    chk("mr_tready", s_tready, 0);
    rst = 1'b0; req = 4'b1111;
    cyc(); settle();
    chk("mr_regrant", grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
